seq_eq_ctrl: RTL and testbench
==============================

Name: seq_eq_ctrl

Overview:
Multi-cycle equality checker controller for wide operands. It captures two WIDTH-bit words on a start request and compares them SLICE bits per cycle, LSB slice first, using a narrow combinational slice comparator. It exits early on the first mismatching slice and reports equality plus the mismatch slice index through a start/busy/done handshake. Used where a full-width comparator is too costly or too slow.

Parameters:
WIDTH, 16, operand width in bits; must be a multiple of SLICE.
SLICE, 2, bits compared per cycle; SLICE >= 1.
(Derived, not overridable: NSLICES = WIDTH/SLICE, must be >= 2; IDX_W = clog2(NSLICES).)

Ports:
clk  in  1  system clock; all state updates on the rising edge.
reset_n  in  1  asynchronous, active-low reset.
start  in  1  request a compare; accepted only in IDLE.
a  in  WIDTH  operand A; sampled on the accepting edge only.
b  in  WIDTH  operand B; sampled on the accepting edge only.
busy  out  1  high while in RUN.
done  out  1  one-cycle pulse when a result is valid.
equal  out  1  1 = all slices matched; valid from done until the next accepted start.
mismatch_idx  out  IDX_W  index of the first mismatching slice; 0 when equal = 1.

Behaviour:
- Reset (reset_n low, async): state = IDLE; busy = 0, done = 0, equal = 0, mismatch_idx = 0; shift registers and slice counter cleared. Reset mid-RUN abandons the compare; no done is produced.
- States: IDLE, RUN, DONE.
- IDLE: on an edge with start = 1, load sa <= a and sb <= b, set cnt <= 0, go to RUN. equal and mismatch_idx keep their previous result until this edge, then clear to 0.
- RUN: busy = 1. The slice comparator checks sa[SLICE-1:0] against sb[SLICE-1:0].
  - On mismatch: equal <= 0, mismatch_idx <= cnt, go to DONE.
  - On match with cnt == NSLICES-1: equal <= 1, mismatch_idx <= 0, go to DONE.
  - On any other match: shift sa and sb right by SLICE, cnt <= cnt+1.
- DONE: done = 1 for exactly one cycle, busy = 0, then go to IDLE unconditionally.
- Latency (E0 = accepting edge): a mismatch at slice k makes done high in the cycle after edge E0+k+1. A full match makes done high after edge E0+NSLICES. busy is high for k+1 or NSLICES cycles respectively.
- start is ignored in RUN and DONE; it is not queued. start held high continuously gives back-to-back compares with exactly one IDLE cycle between done and the next busy.
- a and b may change freely after the accepting edge.
- Counter is IDX_W bits wide and never wraps, because RUN exits at NSLICES-1.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Optional Feature:
Macro SEQ_EQ_CTRL_ABORT_EN.
- Defined: adds input port abort (1 bit). abort = 1 in RUN returns the block to IDLE on the next edge with no done pulse; equal and mismatch_idx stay 0. abort has priority over a result in the same cycle. abort is ignored in IDLE and DONE.
- Undefined: no abort port; RUN always completes.

Decomposition:
- Package seq_eq_pkg: state enum (IDLE, RUN, DONE, 2-bit encoding), and functions/constants for computing NSLICES and IDX_W from WIDTH and SLICE.
- Sub-module seq_eq_slice: purely combinational SLICE-bit equality (bitwise XNOR, AND-reduced); one instance inside seq_eq_ctrl.
- The FSM, shift registers and counter live in seq_eq_ctrl.

Test Plan:
All scenarios use WIDTH = 16, SLICE = 2 (NSLICES = 8, IDX_W = 3).
1. Reset: hold reset_n low mid-RUN, then release -> busy = 0, done = 0, equal = 0, mismatch_idx = 0; no done pulse ever appears for that compare.
2. Full match: a = b = 16'hA5C3, pulse start -> busy high for 8 cycles, then done for 1 cycle with equal = 1, mismatch_idx = 0.
3. Early mismatch: a = 16'h0000, b = 16'h0040 (slice 3), pulse start -> done after 4 busy cycles with equal = 0, mismatch_idx = 3.
4. MSB mismatch: a = 16'h8000, b = 16'h0000 -> 8 busy cycles, then equal = 0, mismatch_idx = 7.
5. Ignore/back-to-back: pulse start again mid-RUN and change a/b -> result reflects the original operands. Then hold start high with a = b -> exactly one IDLE cycle between done and the next busy.
6. SEQ_EQ_CTRL_ABORT_EN defined: assert abort on the 3rd RUN cycle with a = b -> IDLE on the next edge, no done pulse, equal = 0; a following compare completes normally.

Source files
------------

// File: rtl/seq_eq_pkg.sv
// Shared types and sizing helpers for the sequential equality checker.
package seq_eq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of SLICE-bit chunks in a WIDTH-bit operand.
  function automatic int calc_nslices(input int width, input int slice);
    return width / slice;
  endfunction

  // Width of a slice index / counter; NSLICES >= 2 keeps this >= 1.
  function automatic int calc_idx_w(input int width, input int slice);
    return $clog2(width / slice);
  endfunction

endpackage

// File: rtl/seq_eq_slice.sv
// Combinational SLICE-bit equality: XNOR per bit, AND-reduced.
module seq_eq_slice #(
  parameter int SLICE = 2
) (
  input  logic [SLICE-1:0] x,
  input  logic [SLICE-1:0] y,
  output logic             eq
);

  // All bits must agree for the slice to match.
  always_comb eq = &(~(x ^ y));

endmodule

// File: rtl/seq_eq_ctrl.sv
// Multi-cycle equality checker: compares two WIDTH-bit words SLICE bits
// per cycle, LSB slice first, exiting early on the first mismatch.
// Optional macro SEQ_EQ_CTRL_ABORT_EN adds an abort input that cancels a
// running compare without a done pulse.
module seq_eq_ctrl
  import seq_eq_pkg::*;
#(
  parameter  int WIDTH   = 16,
  parameter  int SLICE   = 2,
  localparam int NSLICES = calc_nslices(WIDTH, SLICE),
  localparam int IDX_W   = calc_idx_w(WIDTH, SLICE)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
`ifdef SEQ_EQ_CTRL_ABORT_EN
  input  logic             abort,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             equal,
  output logic [IDX_W-1:0] mismatch_idx
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(NSLICES - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sa, sb;
  logic [IDX_W-1:0] cnt;
  logic             slice_eq;
  logic             abort_run;

`ifdef SEQ_EQ_CTRL_ABORT_EN
  assign abort_run = abort;
`else
  assign abort_run = 1'b0;
`endif

  seq_eq_slice #(.SLICE(SLICE)) u_slice (
    .x  (sa[SLICE-1:0]),
    .y  (sb[SLICE-1:0]),
    .eq (slice_eq)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next state: abort beats a result; last slice or a mismatch ends RUN.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        if (abort_run)                     state_nxt = IDLE;
        else if (!slice_eq || cnt == LAST) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath and registered outputs; busy/done follow the next state so
  // they line up with the state they describe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sa           <= '0;
      sb           <= '0;
      cnt          <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      equal        <= 1'b0;
      mismatch_idx <= '0;
    end else begin
      busy <= (state_nxt == RUN);
      done <= (state_nxt == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            sa           <= a;
            sb           <= b;
            cnt          <= '0;
            equal        <= 1'b0;
            mismatch_idx <= '0;
          end
        end
        RUN: begin
          if (!abort_run) begin
            if (!slice_eq) begin
              equal        <= 1'b0;
              mismatch_idx <= cnt;
            end else if (cnt == LAST) begin
              equal        <= 1'b1;
              mismatch_idx <= '0;
            end else begin
              sa  <= sa >> SLICE;
              sb  <= sb >> SLICE;
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_eq_ctrl.sv
// Self-checking bench for seq_eq_ctrl (WIDTH=16, SLICE=2).
module tb_seq_eq_ctrl;

  localparam int W  = 16;
  localparam int S  = 2;
  localparam int NS = W / S;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic          abort;
  logic [W-1:0]  a, b;
  logic          busy, done, equal;
  logic [2:0]    mismatch_idx;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  seq_eq_ctrl dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
`ifdef SEQ_EQ_CTRL_ABORT_EN
    .abort        (abort),
`endif
    .a            (a),
    .b            (b),
    .busy         (busy),
    .done         (done),
    .equal        (equal),
    .mismatch_idx (mismatch_idx)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    bit           eq;
    int           idx;
    int           nbusy;
  } vec_t;

  vec_t vt[6];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: scan slices from LSB, report first differing one.
  function automatic void ref_cmp(input logic [W-1:0] x, input logic [W-1:0] y,
                                  output bit eq, output int idx, output int nbusy);
    eq = 1'b1; idx = 0; nbusy = NS;
    for (int k = 0; k < NS; k++) begin
      if (((x >> (k * S)) % (1 << S)) != ((y >> (k * S)) % (1 << S))) begin
        eq = 1'b0; idx = k; nbusy = k + 1;
        return;
      end
    end
  endfunction

  // Launch one compare from IDLE and follow it to done (bounded).
  // restart_mid pulses start with different operands during RUN.
  task automatic do_cmp(input logic [W-1:0] xa, input logic [W-1:0] xb,
                        input bit restart_mid,
                        output bit got, output bit eq, output int idx,
                        output int nbusy);
    @(negedge clk);
    a = xa; b = xb; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = W'($urandom); b = ~a;
    got = 1'b0; eq = 1'b0; idx = 0; nbusy = 0;
    for (int c = 0; c < 40; c++) begin
      if (done) begin
        got = 1'b1; eq = equal; idx = int'(mismatch_idx);
        break;
      end
      if (busy) nbusy++;
      start = (restart_mid && c == 1);
      @(negedge clk);
    end
    start = 1'b0;
    check("done_seen", int'(got), 1);
    if (got) begin
      @(negedge clk);
      check("done_one_cycle", int'(done), 0);
      check("result_held_eq", int'(equal), int'(eq));
    end
  endtask

  bit got, eq, req;
  int idx, nb, ridx, rnb;
  logic [W-1:0] ra, rb;
  int saw_done;

  initial begin
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_equal", int'(equal), 0);
    check("rst_idx", int'(mismatch_idx), 0);
    reset_n = 1'b1;

    vt[0] = '{16'hA5C3, 16'hA5C3, 1'b1, 0, 8};
    vt[1] = '{16'h0000, 16'h0040, 1'b0, 3, 4};
    vt[2] = '{16'h8000, 16'h0000, 1'b0, 7, 8};
    vt[3] = '{16'h0003, 16'h0000, 1'b0, 0, 1};
    vt[4] = '{16'h1234, 16'h1634, 1'b0, 5, 6};
    vt[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 0, 8};

    for (int i = 0; i < 6; i++) begin
      do_cmp(vt[i].a, vt[i].b, 1'b0, got, eq, idx, nb);
      check($sformatf("vec%0d_equal", i), int'(eq), int'(vt[i].eq));
      check($sformatf("vec%0d_idx", i), idx, vt[i].idx);
      check($sformatf("vec%0d_busy", i), nb, vt[i].nbusy);
    end

    // start during RUN is ignored; result reflects original operands.
    do_cmp(16'h1234, 16'h1234, 1'b1, got, eq, idx, nb);
    check("ignore_equal", int'(eq), 1);
    check("ignore_busy", nb, 8);

    // start held high: done, one IDLE cycle, then busy again.
    @(negedge clk);
    a = 16'h5A5A; b = 16'h5A5A; start = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done) begin got = 1'b1; break; end
    end
    check("b2b_done", int'(got), 1);
    check("b2b_eq", int'(equal), 1);
    @(negedge clk);
    check("b2b_idle_busy", int'(busy), 0);
    check("b2b_idle_done", int'(done), 0);
    @(negedge clk);
    check("b2b_rebusy", int'(busy), 1);
    start = 1'b0;
    for (int c = 0; c < 40 && !done; c++) @(negedge clk);
    @(negedge clk);

    // Reset mid-RUN: outputs clear, no done for the abandoned compare.
    a = 16'h0000; b = 16'h8000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midrst_busy", int'(busy), 0);
    check("midrst_equal", int'(equal), 0);
    check("midrst_idx", int'(mismatch_idx), 0);
    @(negedge clk);
    reset_n = 1'b1;
    saw_done = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (done || busy) saw_done++;
    end
    check("midrst_no_done", saw_done, 0);

`ifdef SEQ_EQ_CTRL_ABORT_EN
    // Abort on the 3rd RUN cycle: back to IDLE with no done.
    @(negedge clk);
    a = 16'h3C3C; b = 16'h3C3C; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_equal", int'(equal), 0);
    saw_done = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done) saw_done++;
    end
    check("abort_no_done", saw_done, 0);
    do_cmp(16'h3C3C, 16'h3C3C, 1'b0, got, eq, idx, nb);
    check("post_abort_eq", int'(eq), 1);
    check("post_abort_busy", nb, 8);
`endif

    // Randomized compares against the reference model.
    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      case ($urandom_range(0, 2))
        0: rb = ra;
        1: rb = ra ^ (W'($urandom_range(1, 3)) << (S * $urandom_range(0, NS - 1)));
        default: rb = W'($urandom);
      endcase
      ref_cmp(ra, rb, req, ridx, rnb);
      do_cmp(ra, rb, 1'b0, got, eq, idx, nb);
      check($sformatf("rnd%0d_equal", i), int'(eq), int'(req));
      check($sformatf("rnd%0d_idx", i), idx, ridx);
      check($sformatf("rnd%0d_busy", i), nb, rnb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
